// File: rtl/hazard_int_ctrl.sv
// Pipeline sequencing controller: load-use stalls, jump flushes and interrupt entry
// (drain the pipe, inject the INT pseudo-op, then wait for its vector jump in EX).
module hazard_int_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int DRAIN_CYC      = 3,
    parameter int WAIT_MAX       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       interrupt,
    input  logic       INT_enable,
    input  logic       mem_read_EX,
    input  logic [2:0] Rdst1_EX,
    input  logic [2:0] Rsrc_ID,
    input  logic [2:0] Rdst1_ID,
    input  logic       uses_rsrc_ID,
    input  logic       uses_rdst_ID,
    input  logic       do_jmp_EX,
    output logic       stall,
    output logic       flush_IF_ID,
    output logic       flush_ID_EX,
    output logic       int_inject,
    output logic       int_ack,
    output logic       int_err,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LD_STALL   = 3'd1,
        INT_DRAIN  = 3'd2,
        INT_INJECT = 3'd3,
        INT_WAIT   = 3'd4
    } state_t;

    localparam int LW = $clog2(LOAD_STALL_CYC + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);

    state_t        state, next_state;
    logic          pending;
    logic          settle;
    logic [LW-1:0] ld_cnt, ld_cnt_next;
    logic [DW-1:0] drain_cnt, drain_cnt_next;
    logic [WW-1:0] wait_cnt, wait_cnt_next;
    logic          hazard;
    logic          stall_c, flush_if_c, flush_ex_c, inject_c, ack_c, err_c;
    logic          out_mask;

    assign hazard = mem_read_EX &
                    ((uses_rsrc_ID & (Rsrc_ID == Rdst1_EX)) |
                     (uses_rdst_ID & (Rdst1_ID == Rdst1_EX)));

    // settle marks the first cycle after reset, during which every output stays quiet
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            settle    <= 1'b1;
            ld_cnt    <= '0;
            drain_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= next_state;
            settle    <= 1'b0;
            ld_cnt    <= ld_cnt_next;
            drain_cnt <= drain_cnt_next;
            wait_cnt  <= wait_cnt_next;
            if (interrupt && INT_enable)
                pending <= 1'b1;
            else if (next_state == INT_INJECT)
                pending <= 1'b0;
            else if (state == IDLE && !INT_enable)
                pending <= 1'b0;
        end
    end

    always_comb begin
        next_state     = state;
        ld_cnt_next    = ld_cnt;
        drain_cnt_next = drain_cnt;
        wait_cnt_next  = wait_cnt;
        stall_c        = 1'b0;
        flush_if_c     = 1'b0;
        flush_ex_c     = 1'b0;
        inject_c       = 1'b0;
        ack_c          = 1'b0;
        err_c          = 1'b0;

        case (state)
            IDLE: begin
                ld_cnt_next = '0;
                if (do_jmp_EX) begin
                    flush_if_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else if (hazard) begin
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                    if (LOAD_STALL_CYC > 1)
                        next_state = LD_STALL;
                end else if (pending && INT_enable) begin
                    // IF_ID is held by the drain stall, so its PC becomes the return address
                    next_state     = INT_DRAIN;
                    drain_cnt_next = '0;
                end
            end

            LD_STALL: begin
                if (do_jmp_EX) begin
                    flush_if_c  = 1'b1;
                    flush_ex_c  = 1'b1;
                    next_state  = IDLE;
                    ld_cnt_next = '0;
                end else begin
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                    if (ld_cnt == LW'(LOAD_STALL_CYC - 2)) begin
                        next_state  = IDLE;
                        ld_cnt_next = '0;
                    end else begin
                        ld_cnt_next = ld_cnt + LW'(1);
                    end
                end
            end

            INT_DRAIN: begin
                if (do_jmp_EX) begin
                    flush_if_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else begin
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                end
                if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
                    next_state     = INT_INJECT;
                    drain_cnt_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt + DW'(1);
                end
            end

            INT_INJECT: begin
                inject_c = 1'b1;
                ack_c    = 1'b1;
                if (do_jmp_EX) begin
                    flush_if_c = 1'b1;
                    flush_ex_c = 1'b1;
                end
                next_state    = INT_WAIT;
                wait_cnt_next = '0;
            end

            INT_WAIT: begin
                if (do_jmp_EX) begin
                    flush_if_c    = 1'b1;
                    flush_ex_c    = 1'b1;
                    next_state    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    stall_c = 1'b1;
                    if (wait_cnt == WW'(WAIT_MAX - 1)) begin
                        err_c         = 1'b1;
                        next_state    = IDLE;
                        wait_cnt_next = '0;
                    end else begin
                        wait_cnt_next = wait_cnt + WW'(1);
                    end
                end
            end

            default: next_state = IDLE;
        endcase

        if (settle)
            next_state = IDLE;
    end

    assign out_mask    = reset | settle;
    assign stall       = stall_c    & ~out_mask;
    assign flush_IF_ID = flush_if_c & ~out_mask;
    assign flush_ID_EX = flush_ex_c & ~out_mask;
    assign int_inject  = inject_c   & ~out_mask;
    assign int_ack     = ack_c      & ~out_mask;
    assign int_err     = err_c      & ~out_mask;
    assign fsm_state   = reset ? 3'd0 : state;

endmodule
